// File: rtl/temporal_ngram_encoder.sv
// Temporal N-gram encoder: XORs the current spatial HV with rotated copies of the previous NGRAM_SIZE-1 HVs.
// Optional `TEMPORAL_BYPASS_EN adds BypassIn_SI, which forwards the raw input HV instead of the N-gram.
module temporal_ngram_encoder #(
  parameter int unsigned HV_DIMENSION = 2000,
  parameter int unsigned NGRAM_SIZE   = 3
) (
  input  logic                    Clk_CI,
  input  logic                    Reset_RI,
  input  logic                    ValidIn_SI,
  output logic                    ReadyOut_SO,
  input  logic [0:HV_DIMENSION-1] HypervectorIn_DI,
  input  logic                    FlushIn_SI,
`ifdef TEMPORAL_BYPASS_EN
  input  logic                    BypassIn_SI,
`endif
  output logic                    ValidOut_SO,
  input  logic                    ReadyIn_SI,
  output logic [0:HV_DIMENSION-1] NGramOut_DO
);

  localparam int unsigned HIST_DEPTH = (NGRAM_SIZE > 1) ? NGRAM_SIZE - 1 : 1;
  localparam int unsigned CNT_W      = $clog2(NGRAM_SIZE) + 1;
  localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(NGRAM_SIZE - 1);

  typedef enum logic {WARMUP, STREAM} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        fill_q, fill_d, fill_base;
  logic [0:HV_DIMENSION-1] hist_q [HIST_DEPTH];
  logic [0:HV_DIMENSION-1] hist_d [HIST_DEPTH];
  logic [0:HV_DIMENSION-1] hist_base [HIST_DEPTH];
  logic [0:HV_DIMENSION-1] ngram_q, ngram_d, ngram_calc;
  logic                    valid_q, valid_d;
  logic                    accept, streaming;

  function automatic logic [0:HV_DIMENSION-1] rho(input logic [0:HV_DIMENSION-1] x);
    return {x[HV_DIMENSION-1], x[0:HV_DIMENSION-2]};
  endfunction

  assign ReadyOut_SO = !valid_q || ReadyIn_SI;
  assign accept      = ValidIn_SI && ReadyOut_SO;
  // A single-HV N-gram has no history, so it streams from the first accept.
  assign streaming   = (state_q == STREAM) || (NGRAM_SIZE == 1);
  assign ValidOut_SO = valid_q;
  assign NGramOut_DO = ngram_q;

  always_comb begin
    ngram_calc = HypervectorIn_DI;
    if (NGRAM_SIZE > 1) begin
      for (int unsigned k = 0; k < HIST_DEPTH; k++) ngram_calc = ngram_calc ^ hist_q[k];
    end
  end

  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    hist_d    = hist_q;
    ngram_d   = ngram_q;
    valid_d   = valid_q;
    hist_base = hist_q;
    fill_base = fill_q;

    if (valid_q && ReadyIn_SI) valid_d = 1'b0;

    // Flush is applied before the accept, so a same-cycle HV lands in an empty history.
    if (FlushIn_SI) begin
      for (int unsigned k = 0; k < HIST_DEPTH; k++) hist_base[k] = '0;
      fill_base = '0;
      hist_d    = hist_base;
      fill_d    = '0;
      state_d   = WARMUP;
    end

    if (accept) begin
      // History entries are stored pre-rotated: entry k holds rho^(k+1) of its HV.
      for (int unsigned k = 1; k < HIST_DEPTH; k++) hist_d[k] = rho(hist_base[k-1]);
      hist_d[0] = rho(HypervectorIn_DI);

      fill_d  = (fill_base < FILL_MAX) ? fill_base + CNT_W'(1) : fill_base;
      state_d = (fill_d >= FILL_MAX) ? STREAM : WARMUP;

      if (!FlushIn_SI && streaming) begin
        ngram_d = ngram_calc;
        valid_d = 1'b1;
      end
`ifdef TEMPORAL_BYPASS_EN
      if (BypassIn_SI) begin
        ngram_d = HypervectorIn_DI;
        valid_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (Reset_RI) begin
      state_q <= WARMUP;
      fill_q  <= '0;
      ngram_q <= '0;
      valid_q <= 1'b0;
      for (int unsigned k = 0; k < HIST_DEPTH; k++) hist_q[k] <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      ngram_q <= ngram_d;
      valid_q <= valid_d;
      hist_q  <= hist_d;
    end
  end

endmodule

// File: tb/tb_temporal_ngram_encoder.sv
// Scoreboarded bench for temporal_ngram_encoder (HV_DIMENSION=8, NGRAM_SIZE=3, bit 0 = MSB).
module tb_temporal_ngram_encoder;
  localparam int unsigned N = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vin = 1'b0;
  logic       rdy_out;
  logic [7:0] hv_in = '0;
  logic       flush = 1'b0;
  logic       vout;
  logic       rdy_in = 1'b0;
  logic [7:0] ngram;

  int n_total = 0;
  int n_pass  = 0;

  logic [7:0] exp_q [$];
  logic [7:0] hist [$];
  logic       obs_valid, obs_rdy;
  logic [7:0] obs_data;
  logic       hold_pending = 1'b0;
  logic [7:0] hold_val = '0;

  always #5 clk = ~clk;

  temporal_ngram_encoder #(.HV_DIMENSION(8), .NGRAM_SIZE(N)) dut (
    .Clk_CI(clk),
    .Reset_RI(rst),
    .ValidIn_SI(vin),
    .ReadyOut_SO(rdy_out),
    .HypervectorIn_DI(hv_in),
    .FlushIn_SI(flush),
`ifdef TEMPORAL_BYPASS_EN
    .BypassIn_SI(1'b0),
`endif
    .ValidOut_SO(vout),
    .ReadyIn_SI(rdy_in),
    .NGramOut_DO(ngram)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
  endtask

  // rho with bit 0 as MSB is an ordinary rotate right of the 8-bit value.
  function automatic logic [7:0] rotr(input logic [7:0] x, input int n);
    logic [7:0] y = x;
    for (int i = 0; i < n; i++) y = {y[0], y[7:1]};
    return y;
  endfunction

  // Reference: raw past HVs, newest first; an N-gram exists once N-1 of them are held.
  task automatic model(input logic acc, input logic [7:0] d, input logic f);
    logic [7:0] e;
    if (f) hist.delete();
    if (acc) begin
      if (!f && hist.size() == N - 1) begin
        e = d;
        for (int k = 0; k < hist.size(); k++) e ^= rotr(hist[k], k + 1);
        exp_q.push_back(e);
      end
      hist.push_front(d);
      while (hist.size() > N - 1) void'(hist.pop_back());
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic f, input logic r);
    logic acc;
    vin = v; hv_in = d; flush = f; rdy_in = r;
    @(negedge clk);
    obs_valid = vout; obs_data = ngram; obs_rdy = rdy_out;
    acc = v && rdy_out;
    @(posedge clk);
    model(acc, d, f);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; vin = 1'b0; flush = 1'b0; rdy_in = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    hist.delete();
  endtask

  // Monitor: every output transfer is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst) hold_pending = 1'b0;
    else begin
      if (hold_pending) begin
        chk("hold_valid", {7'd0, vout}, 8'd1);
        chk("hold_data", ngram, hold_val);
      end
      chk("ready_out", {7'd0, rdy_out}, {7'd0, (!vout || rdy_in)});
      if (vout && rdy_in) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL spurious_output: got %02h expected no output at %0t", ngram, $time);
        end else chk("ngram", ngram, exp_q.pop_front());
      end
      hold_pending = vout && !rdy_in;
      hold_val     = ngram;
    end
  end

  initial begin
    do_reset();
    do_reset();
    step(0, 8'h00, 0, 1);
    chk("reset_valid", {7'd0, obs_valid}, 8'd0);
    chk("reset_data", obs_data, 8'h00);
    chk("reset_ready", {7'd0, obs_rdy}, 8'd1);

    step(1, 8'h80, 0, 1);
    step(1, 8'h01, 0, 1);
    chk("warmup1_valid", {7'd0, obs_valid}, 8'd0);
    step(1, 8'h0F, 0, 1);
    chk("warmup2_valid", {7'd0, obs_valid}, 8'd0);
    step(0, 8'h00, 0, 0);
    chk("first_valid", {7'd0, obs_valid}, 8'd1);
    chk("first_data", obs_data, 8'hAF);
    step(1, 8'hFF, 0, 0);
    chk("stall_ready", {7'd0, obs_rdy}, 8'd0);
    chk("stall_data", obs_data, 8'hAF);
    step(1, 8'hFF, 0, 1);
    chk("release_ready", {7'd0, obs_rdy}, 8'd1);
    step(0, 8'h00, 0, 1);
    chk("second_valid", {7'd0, obs_valid}, 8'd1);
    chk("second_data", obs_data, 8'h38);

    step(1, 8'h55, 1, 1);
    step(1, 8'h00, 0, 1);
    chk("flush_no_out", {7'd0, obs_valid}, 8'd0);
    step(1, 8'h00, 0, 1);
    chk("flush_warm_out", {7'd0, obs_valid}, 8'd0);
    step(0, 8'h00, 0, 1);
    chk("flush_valid", {7'd0, obs_valid}, 8'd1);
    chk("flush_data", obs_data, 8'h55);

    step(1, 8'h80, 0, 1);
    step(1, 8'h01, 0, 1);
    step(1, 8'h0F, 0, 1);
    step(0, 8'h00, 0, 0);
    chk("pre_reset_valid", {7'd0, obs_valid}, 8'd1);
    do_reset();
    step(0, 8'h00, 0, 1);
    chk("midreset_valid", {7'd0, obs_valid}, 8'd0);
    chk("midreset_data", obs_data, 8'h00);
    step(1, 8'h12, 0, 1);
    step(1, 8'h34, 0, 1);
    chk("rewarm1", {7'd0, obs_valid}, 8'd0);
    step(1, 8'h56, 0, 1);
    chk("rewarm2", {7'd0, obs_valid}, 8'd0);
    step(0, 8'h00, 0, 1);
    chk("rewarm_valid", {7'd0, obs_valid}, 8'd1);

    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 699) do_reset();
      else step(($urandom % 4) != 0, 8'($urandom), ($urandom % 16) == 0, ($urandom % 4) != 0);
    end
    for (int i = 0; i < 6; i++) step(0, 8'h00, 0, 1);
    chk("drain_empty", 8'(exp_q.size()), 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
